byte_stream_fifo: RTL
=====================

# byte_stream_fifo

Elastic buffer between a free-running byte producer (valid-only, no backpressure) and a downstream consumer stage that uses a valid/ready handshake. It absorbs bursts from the producer and presents words in order to the consumer. It reports occupancy, and raises a sticky flag when a byte is dropped because the buffer is full.

## Interface
Parameters:
- DATA_W, 8, width of each data word.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_W  upstream data word.
- valid_in  input  1  upstream word present this cycle; cannot be stalled.
- data_out  output  DATA_W  head-of-buffer word.
- valid_out  output  1  buffer non-empty; data_out is valid.
- ready_in  input  1  downstream accepts data_out this cycle.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one input word was dropped.
- ovf_clr  input  1  synchronous clear for overflow.

## Operation
- Push: a push occurs when valid_in=1 and the buffer is not full, or when the buffer is full and a pop occurs in the same cycle.
- Drop: valid_in=1 while full with no pop drops the word. Storage and count are unchanged, and overflow sets on the next edge.
- Pop: a pop occurs when valid_out=1 and ready_in=1. The read pointer advances.
- First-word-fall-through output:
  - valid_out = (count != 0).
  - data_out = storage[rd_ptr] while valid_out=1, otherwise all zeros.
- Occupancy states (derived from count, no separate state register): EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on a push without a pop when count=DEPTH-1.
  - FULL→PARTIAL on a pop without a push.
  - PARTIAL→EMPTY on a pop without a push when count=1.
  - Simultaneous push and pop leaves count unchanged in every state.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer comparison.
- EMPTY with valid_in=1: no bypass. The word is written, and valid_out rises on the next cycle. ready_in has no effect while empty.
- ovf_clr:
  - ovf_clr=1 clears overflow on the next edge.
  - If a drop occurs in the same cycle as ovf_clr, set wins and overflow stays 1.
- Reset (rst_n=0, asynchronous, effective at any time including mid-burst):
  - Pointers and count go to 0; overflow=0; valid_out=0; data_out=0.
  - Stored contents are discarded; storage itself is not cleared.
- Reset release is synchronised by the system. The block accepts valid_in on the first clk edge after rst_n rises.

## Timing
- Latency from push to visibility: word pushed at edge N is on data_out with valid_out=1 after edge N, i.e. in cycle N+1, when the buffer was empty.
- Throughput: one push and one pop per cycle, sustained.
- count, valid_out and overflow are registered or derived only from registers. No combinational path from ready_in or valid_in to any output.
- data_out changes only after a clk edge on which a pop or a push-into-empty occurred.

## Structure
- Package byte_stream_pkg holds:
  - parameter defaults (DATA_W, DEPTH);
  - a derived pointer-width function;
  - an occupancy enum (EMPTY, PARTIAL, FULL) for debug and assertions.
- Sub-module byte_stream_ram: DEPTH×DATA_W register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on the array.
- The top level holds pointers, count, overflow and the handshake logic.

## Test plan
- Reset: assert rst_n=0 mid-operation with count=3 → asynchronously count=0, valid_out=0, data_out=0x00, overflow=0. First push after release appears one cycle later.
- Fill: ready_in=0, push 0x11,0x22,0x33,0x44 → count=4, valid_out=1, data_out=0x11, overflow=0.
- Overflow: continue from Fill, push 0x55 with ready_in=0 → count stays 4, overflow=1 next cycle. Drain yields 0x11,0x22,0x33,0x44 only.
- Full push+pop: at count=4, push 0x55 with ready_in=1 → 0x11 popped, 0x55 stored, count=4, overflow unchanged. Full drain ends with 0x55.
- Wrap: 10 back-to-back pushes 0x00..0x09 with ready_in=1 on every cycle → data_out sequence 0x00..0x09 each one cycle after its push, count never exceeds 1, no drop.
- Clear race: overflow=1; pulse ovf_clr with a simultaneous full-drop → overflow remains 1. Pulse ovf_clr alone next cycle → overflow=0.

Source files
------------

// File: rtl/byte_stream_pkg.sv
// Shared defaults, pointer-width helper and occupancy encoding for the byte stream buffer.
package byte_stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_e;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/byte_stream_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module byte_stream_ram
    import byte_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = ptr_w(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: the array has no reset; occupancy lives in the pointers and count,
    // so stale contents are never presented and a reset tree here buys nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/byte_stream_fifo.sv
// Elastic buffer: valid-only byte producer in, valid/ready consumer out, sticky drop flag.
module byte_stream_fifo
    import byte_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       valid_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] rdata;
    occ_e              occ;
    logic              is_full, push, pop, drop;

    always_comb begin
        if (count_q == '0)            occ = EMPTY;
        else if (count_q == CNT_FULL) occ = FULL;
        else                          occ = PARTIAL;
    end

    assign valid_out = (occ != EMPTY);
    assign is_full   = (occ == FULL);
    assign pop       = valid_out & ready_in;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign push      = valid_in & (~is_full | pop);
    assign drop      = valid_in & is_full & ~pop;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (drop)         overflow_d = 1'b1;
        else if (ovf_clr) overflow_d = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    byte_stream_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign data_out = valid_out ? rdata : '0;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
